// File: rtl/mode_select_pkg.sv
// Shared types and helpers for the front-panel mode selector.
package mode_select_pkg;

  // Widest button vector the priority helper accepts.
  localparam int MAX_BTN = 32;

  typedef enum logic {
    ST_IDLE,
    ST_GUARD
  } state_t;

  // Index of the lowest set bit (bit 0 has highest priority); 0 when none set.
  function automatic int unsigned lowest_set(input logic [MAX_BTN-1:0] v);
    lowest_set = 0;
    for (int i = MAX_BTN - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = unsigned'(i);
    end
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Press-edge detector: one history register per input, reset to all-ones.
// rise is combinational from the current input; a level held through reset never produces an edge.
module btn_edge_detect #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] btn,
  output logic [W-1:0] rise
);

  logic [W-1:0] btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= '1;
    else        btn_q <= btn;
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/mode_select.sv
// Front-panel mode selector: press edges pick a mode, fixed priority, lockout guard after each change.
// mode/mode_chg update one cycle after a press; presses during the guard are dropped. Option: MODE_SEL_STEP_EN.
module mode_select
  import mode_select_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int GUARD_CYCLES = 50000,
  parameter int RESET_MODE   = 0,
  localparam int SW = (N_BTN > 1) ? $clog2(N_BTN) : 1,
  localparam int CW = ($clog2(GUARD_CYCLES + 1) > 0) ? $clog2(GUARD_CYCLES + 1) : 1
) (
  input  logic             clk_50MHz,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
`ifdef MODE_SEL_STEP_EN
  input  logic             btn_next,
  input  logic             btn_prev,
`endif
  output logic [SW-1:0]    mode,
  output logic             mode_chg,
  output logic             busy
);

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [SW-1:0]   mode_d;
  logic            mode_chg_d;
  logic            busy_d;
  logic [N_BTN-1:0] rise;
  logic [SW-1:0]   sel;
  logic [SW-1:0]   req_mode;
  logic            req_vld;

  btn_edge_detect #(.W(N_BTN)) u_btn_edge (
    .clk   (clk_50MHz),
    .rst_n (rst_n),
    .btn   (btn),
    .rise  (rise)
  );

  assign sel = SW'(lowest_set(MAX_BTN'(rise)));

`ifdef MODE_SEL_STEP_EN
  logic [1:0] step_rise;

  btn_edge_detect #(.W(2)) u_step_edge (
    .clk   (clk_50MHz),
    .rst_n (rst_n),
    .btn   ({btn_next, btn_prev}),
    .rise  (step_rise)
  );

  // Direct select beats stepping; simultaneous next+prev cancel out.
  always_comb begin
    req_mode = mode;
    req_vld  = 1'b0;
    if (|rise) begin
      req_mode = sel;
      req_vld  = (sel != mode);
    end else if (step_rise == 2'b10) begin
      req_mode = (mode == SW'(N_BTN - 1)) ? '0 : mode + SW'(1);
      req_vld  = 1'b1;
    end else if (step_rise == 2'b01) begin
      req_mode = (mode == '0) ? SW'(N_BTN - 1) : mode - SW'(1);
      req_vld  = 1'b1;
    end
  end
`else
  always_comb begin
    req_mode = sel;
    req_vld  = (|rise) && (sel != mode);
  end
`endif

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    mode_d     = mode;
    mode_chg_d = 1'b0;
    busy_d     = busy;
    case (state)
      ST_IDLE: begin
        if (req_vld) begin
          mode_d     = req_mode;
          mode_chg_d = 1'b1;
          if (GUARD_CYCLES > 0) begin
            state_d = ST_GUARD;
            cnt_d   = CW'(GUARD_CYCLES - 1);
            busy_d  = 1'b1;
          end
        end
      end
      ST_GUARD: begin
        // Edges seen here are discarded; history still advances so held buttons stay quiet.
        if (cnt == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= SW'(RESET_MODE);
      mode_chg <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
    end else begin
      mode     <= mode_d;
      mode_chg <= mode_chg_d;
      busy     <= busy_d;
      cnt      <= cnt_d;
    end
  end

endmodule
